// File: rtl/csr_responder.sv
// Host CSR responder: a bank of wide registers with posted writes, handshaked
// read completions, per-register write strobes and read-only counter/status registers.
module csr_responder #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned ADDR_LSB   = 6,
  parameter logic [31:0] CSR_BASE   = 32'h0000_0000
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [31:0]                    req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wrData,
  output logic                           cpl_valid,
  input  logic                           cpl_ready,
  output logic [DATA_WIDTH-1:0]          cpl_rdData,
  output logic                           cpl_err,
  input  logic [DATA_WIDTH-1:0]          status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] csr_q,
  output logic [NUM_REGS-1:0]            csr_wr_pulse
);

  localparam int unsigned IDX_W   = $clog2(NUM_REGS);
  localparam int unsigned CNT_REG = NUM_REGS - 2;
  localparam int unsigned STS_REG = NUM_REGS - 1;
  localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(CNT_REG);
  localparam logic [IDX_W-1:0] STS_IDX = IDX_W'(STS_REG);

  typedef enum logic {IDLE, RESP} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   rw_regs [CNT_REG];
  logic [31:0]             wr_cnt;
  logic [31:0]             rd_cnt;
  logic [31:0]             miss_cnt;

  logic [31:0]             off;
  logic [IDX_W-1:0]        idx;
  logic                    hit;
  logic                    wr_ok;
  logic [DATA_WIDTH-1:0]   cnt_word;
  logic [DATA_WIDTH-1:0]   rd_word;

  function automatic logic [DATA_WIDTH-1:0] pack_counters(
    input logic [31:0] w, input logic [31:0] r, input logic [31:0] m);
    logic [DATA_WIDTH-1:0] v;
    v        = '0;
    v[31:0]  = w;
    v[63:32] = r;
    v[95:64] = m;
    return v;
  endfunction

  // Decode: wrap-around offset from the bank base, low ADDR_LSB bits ignored
  assign off      = req_addr - CSR_BASE;
  assign idx      = off[ADDR_LSB +: IDX_W];
  assign hit      = (off >> ADDR_LSB) < 32'(NUM_REGS);
  assign wr_ok    = hit && (idx < CNT_IDX);
  assign cnt_word = pack_counters(wr_cnt, rd_cnt, miss_cnt);

  always_comb begin
    rd_word = '0;
    if (hit) begin
      if (idx == CNT_IDX)      rd_word = cnt_word;
      else if (idx == STS_IDX) rd_word = status_in;
      else                     rd_word = rw_regs[idx];
    end
  end

  // The status slot of csr_q mirrors the live status input
  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_q
    if (i < int'(CNT_REG)) begin : g_rw
      assign csr_q[i*DATA_WIDTH +: DATA_WIDTH] = rw_regs[i];
    end else if (i == int'(CNT_REG)) begin : g_cnt
      assign csr_q[i*DATA_WIDTH +: DATA_WIDTH] = cnt_word;
    end else begin : g_sts
      assign csr_q[i*DATA_WIDTH +: DATA_WIDTH] = status_in;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      cpl_valid    <= 1'b0;
      cpl_rdData   <= '0;
      cpl_err      <= 1'b0;
      csr_wr_pulse <= '0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      miss_cnt     <= '0;
      for (int i = 0; i < int'(CNT_REG); i++) rw_regs[i] <= '0;
    end else begin
      csr_wr_pulse <= '0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            if (req_write) begin
              if (wr_ok) begin
                rw_regs[idx]      <= req_wrData;
                csr_wr_pulse[idx] <= 1'b1;
                wr_cnt            <= wr_cnt + 32'd1;
              end
              if (!hit) miss_cnt <= miss_cnt + 32'd1;
            end else begin
              cpl_rdData <= rd_word;
              cpl_err    <= !hit;
              cpl_valid  <= 1'b1;
              rd_cnt     <= rd_cnt + 32'd1;
              if (!hit) miss_cnt <= miss_cnt + 32'd1;
              req_ready  <= 1'b0;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          if (cpl_ready) begin
            cpl_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_responder.sv
// Directed bench for csr_responder: expected completions are queued at issue
// time and checked by an independent monitor on each completion handshake.
module tb_csr_responder;

  localparam int DW = 512;
  localparam int NR = 8;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [DW-1:0]     req_wrData;
  logic              cpl_valid;
  logic              cpl_ready;
  logic [DW-1:0]     cpl_rdData;
  logic              cpl_err;
  logic [DW-1:0]     status_in;
  logic [NR*DW-1:0]  csr_q;
  logic [NR-1:0]     csr_wr_pulse;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  csr_responder #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_LSB(6), .CSR_BASE(32'h0)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wrData(req_wrData),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_rdData(cpl_rdData),
    .cpl_err(cpl_err), .status_in(status_in), .csr_q(csr_q),
    .csr_wr_pulse(csr_wr_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] cnts(input logic [31:0] w, input logic [31:0] r,
                                         input logic [31:0] m);
    return {416'b0, m, r, w};
  endfunction

  function automatic exp_t mk(input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.d = d;
    x.e = e;
    return x;
  endfunction

  // Monitor: one pop per completion handshake, sampled mid-cycle
  always @(negedge sys_clk) begin
    if (sys_rst_n && cpl_valid && cpl_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cpl", {511'b0, cpl_valid}, '0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cpl_rdData", cpl_rdData, e.d);
        chk("cpl_err", {511'b0, cpl_err}, {511'b0, e.e});
      end
    end
  end

  // Returns #1 after the accept edge
  task automatic issue(input logic wr, input logic [31:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wrData = d;
    while (!req_ready && n < 50) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk("req_ready_wait", {511'b0, req_ready}, 512'd1);
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cpl_valid && n < 100) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk("drain", {511'b0, cpl_valid}, '0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_req_ready", {511'b0, req_ready}, '0);
    chk("rst_cpl_valid", {511'b0, cpl_valid}, '0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    chk("rel_req_ready", {511'b0, req_ready}, 512'd1);
  endtask

  initial begin
    sys_rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wrData = '0; cpl_ready = 1'b1; status_in = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_req_ready", {511'b0, req_ready}, '0);
    chk("rst_cpl_valid", {511'b0, cpl_valid}, '0);
    chk("rst_cpl_rdData", cpl_rdData, '0);
    chk("rst_cpl_err", {511'b0, cpl_err}, '0);
    chk("rst_pulse", {504'b0, csr_wr_pulse}, '0);
    chk("rst_csr_q0", csr_q[511:0], '0);
    chk("rst_csr_q5", csr_q[5*DW +: DW], '0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    chk("rel_req_ready", {511'b0, req_ready}, 512'd1);

    // Write reg0 then read it back
    issue(1'b1, 32'h0, 512'd10);
    chk("wr0_pulse", {504'b0, csr_wr_pulse}, 512'h01);
    chk("wr0_csr_q", csr_q[511:0], 512'd10);
    @(posedge sys_clk); #1;
    chk("wr0_pulse_clear", {504'b0, csr_wr_pulse}, '0);
    exp_q.push_back(mk(512'd10, 1'b0));
    issue(1'b0, 32'h0, '0);
    chk("rd0_latency", {511'b0, cpl_valid}, 512'd1);
    wait_idle();

    // Stalled completion with a second request held
    issue(1'b1, 32'h40, 512'h55);
    cpl_ready = 1'b0;
    exp_q.push_back(mk(512'h55, 1'b0));
    issue(1'b0, 32'h40, '0);
    exp_q.push_back(mk(512'd10, 1'b0));
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge sys_clk); #1;
      chk("stall_req_ready", {511'b0, req_ready}, '0);
      chk("stall_cpl_valid", {511'b0, cpl_valid}, 512'd1);
      chk("stall_rdData", cpl_rdData, 512'h55);
    end
    cpl_ready = 1'b1;
    @(posedge sys_clk); #1;
    chk("hs_req_ready", {511'b0, req_ready}, 512'd1);
    chk("hs_cpl_valid", {511'b0, cpl_valid}, '0);
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
    chk("second_accepted", {511'b0, cpl_valid}, 512'd1);
    wait_idle();

    // Unmapped write and read, then counters
    issue(1'b1, 32'h200, 512'h77);
    chk("miss_wr_pulse", {504'b0, csr_wr_pulse}, '0);
    exp_q.push_back(mk('0, 1'b1));
    issue(1'b0, 32'h200, '0);
    wait_idle();
    exp_q.push_back(mk(cnts(32'd2, 32'd4, 32'd2), 1'b0));
    issue(1'b0, 32'h180, '0);
    wait_idle();

    // Status register: writes ignored, read samples at accept
    status_in = 512'hABCD;
    issue(1'b1, 32'h1C0, 512'hFFFF);
    chk("sts_wr_pulse", {504'b0, csr_wr_pulse}, '0);
    exp_q.push_back(mk(512'hABCD, 1'b0));
    issue(1'b0, 32'h1C0, '0);
    status_in = 512'h1234;
    wait_idle();

    // Fresh counters: 3 back-to-back writes, read-after-write, counters
    do_reset();
    issue(1'b1, 32'h0, 512'd1);
    chk("b2b_pulse0", {504'b0, csr_wr_pulse}, 512'h01);
    issue(1'b1, 32'h40, 512'd2);
    chk("b2b_pulse1", {504'b0, csr_wr_pulse}, 512'h02);
    issue(1'b1, 32'h80, 512'd3);
    chk("b2b_pulse2", {504'b0, csr_wr_pulse}, 512'h04);
    chk("csr_q2", csr_q[2*DW +: DW], 512'd3);
    exp_q.push_back(mk(512'd3, 1'b0));
    issue(1'b0, 32'h80, '0);
    wait_idle();
    exp_q.push_back(mk(cnts(32'd3, 32'd1, 32'd0), 1'b0));
    issue(1'b0, 32'h180, '0);
    wait_idle();
    exp_q.push_back(mk(512'd2, 1'b0));
    issue(1'b0, 32'h47, '0);
    wait_idle();

    // Reset while a completion is pending
    cpl_ready = 1'b0;
    issue(1'b0, 32'h40, '0);
    chk("pend_cpl_valid", {511'b0, cpl_valid}, 512'd1);
    do_reset();
    cpl_ready = 1'b1;
    chk("post_rst_cpl_valid", {511'b0, cpl_valid}, '0);
    chk("post_rst_csr_q1", csr_q[1*DW +: DW], '0);
    exp_q.push_back(mk('0, 1'b0));
    issue(1'b0, 32'h0, '0);
    wait_idle();

    repeat (2) @(posedge sys_clk);
    #1;
    chk("sb_empty", 512'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
